// File: rtl/vault_work_scheduler.sv
// rtl/vault_work_scheduler.sv - round-robin nonce-chunk scheduler for a bank of SHA-256d cores
//
// Purpose: latches a work package, splits the 32-bit nonce space into chunks of
// 2^CHUNK_LOG2 nonces, and hands chunks round-robin to idle cores. Found nonces
// are funnelled into one result register with a valid/ready handshake. New
// work arriving while running flushes all cores before restarting.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_work_valid/o_work_ready/i_work_data   work package input handshake
//   o_core_work           latched work shared by all cores
//   o_core_start          one-hot start pulse; o_core_base is the chunk base nonce
//   o_core_flush          one-cycle abort pulse to all cores
//   i_core_busy           per-core busy, rises the cycle after start
//   i_core_found/i_core_nonce  per-core found pulse and nonce (core i at [32i+31:32i])
//   o_res_valid/i_res_ready/o_res_nonce     found-nonce output handshake
//   o_exhausted           whole nonce space issued for the current work
//   o_dropped_count       saturating count of lost found reports
module vault_work_scheduler #(
    parameter int N_CORES    = 4,
    parameter int CHUNK_LOG2 = 20,
    parameter int WORK_W     = 640
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_work_valid,
    output logic                   o_work_ready,
    input  logic [WORK_W-1:0]      i_work_data,
    output logic [WORK_W-1:0]      o_core_work,
    output logic [N_CORES-1:0]     o_core_start,
    output logic [31:0]            o_core_base,
    output logic                   o_core_flush,
    input  logic [N_CORES-1:0]     i_core_busy,
    input  logic [N_CORES-1:0]     i_core_found,
    input  logic [32*N_CORES-1:0]  i_core_nonce,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [31:0]            o_res_nonce,
    output logic                   o_exhausted,
    output logic [15:0]            o_dropped_count
);

    localparam int                 PTR_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [31:0]        CHUNK_STEP  = 32'd1 << CHUNK_LOG2;
    localparam logic [32:0]        CHUNK_LIMIT = 33'd1 << (32 - CHUNK_LOG2);
    localparam logic [N_CORES-1:0] CORE_ONE    = N_CORES'(1);
    localparam logic [PTR_W-1:0]   PTR_LAST    = PTR_W'(N_CORES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WORK_W-1:0]    r_core_work;
    logic [WORK_W-1:0]    r_pend_work;
    logic                 r_pend_valid;
    logic [N_CORES-1:0]   r_core_start;
    logic [N_CORES-1:0]   r_holdoff;
    logic [31:0]          r_core_base;
    logic [31:0]          r_next_base;
    logic [32:0]          r_chunks;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_core_flush;
    logic                 r_flush_done;
    logic                 r_exhausted;
    logic                 r_res_valid;
    logic [31:0]          r_res_nonce;
    logic [15:0]          r_dropped;

    logic                 w_work_accept;
    logic                 w_flush_exit;
    logic                 w_fresh_job;
    logic                 w_dispatch_ok;
    logic                 w_res_en;
    logic [PTR_W-1:0]     w_scan_base;
    logic [31:0]          w_base_now;
    logic [32:0]          w_chunks_now;
    logic [32:0]          w_chunks_inc;
    logic [N_CORES-1:0]   w_eligible;
    logic [PTR_W-1:0]     w_scan_idx;
    logic                 w_pick_ok;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_start;
    logic [N_CORES-1:0]   w_found_gated;
    logic                 w_any_found;
    logic [PTR_W-1:0]     w_win_idx;
    logic [31:0]          w_win_nonce;
    logic [4:0]           w_found_cnt;
    logic                 w_res_take;
    logic [4:0]           w_drop_n;
    logic [16:0]          w_drop_sum;

    assign o_work_ready    = ~i_rst & (r_state != S_FLUSH);
    assign o_core_work     = r_core_work;
    assign o_core_start    = r_core_start;
    assign o_core_base     = r_core_base;
    assign o_core_flush    = r_core_flush;
    assign o_res_valid     = r_res_valid;
    assign o_res_nonce     = r_res_nonce;
    assign o_exhausted     = r_exhausted;
    assign o_dropped_count = r_dropped;

    assign w_work_accept = i_work_valid & o_work_ready;
    // Leave FLUSH only once the flush pulse has been seen by the cores and they all went idle.
    assign w_flush_exit  = (r_state == S_FLUSH) & r_flush_done & r_pend_valid & (i_core_busy == '0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_work_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_work_accept) begin
                    w_state_next = S_FLUSH;
                end else if (r_exhausted && (i_core_busy == '0) && (r_holdoff == '0)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_flush_exit) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output/control decode. The IDLE accept and the FLUSH exit both dispatch
    // straight away from base 0 so the first start lands one cycle later.
    always_comb begin
        w_fresh_job   = 1'b0;
        w_dispatch_ok = 1'b0;
        w_res_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dispatch_ok = w_work_accept;
                w_fresh_job   = 1'b1;
                w_res_en      = 1'b1;
            end
            S_RUN: begin
                w_dispatch_ok = ~w_work_accept & ~r_exhausted;
                w_res_en      = ~w_work_accept;
            end
            S_FLUSH: begin
                w_dispatch_ok = w_flush_exit;
                w_fresh_job   = 1'b1;
            end
            default: ;
        endcase
        w_scan_base  = (r_state == S_FLUSH) ? '0 : r_rr_ptr;
        w_base_now   = w_fresh_job ? 32'd0 : r_next_base;
        w_chunks_now = w_fresh_job ? 33'd0 : r_chunks;
        w_chunks_inc = w_chunks_now + 33'd1;
    end

    // Holdoff masks a core for the cycle its start is visible, before its busy rises.
    assign w_eligible = ~i_core_busy & ~r_holdoff;

    // Rotating priority scan; iterating from the far end lets the nearest hit win.
    always_comb begin
        w_pick_ok  = 1'b0;
        w_pick_idx = '0;
        w_scan_idx = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            w_scan_idx = PTR_W'((32'(w_scan_base) + 32'(k)) % 32'(N_CORES));
            if (w_eligible[w_scan_idx]) begin
                w_pick_ok  = 1'b1;
                w_pick_idx = w_scan_idx;
            end
        end
    end

    assign w_start = w_dispatch_ok & w_pick_ok;

    // Result arbitration: lowest index wins, every other report counts as dropped.
    assign w_found_gated = i_core_found & {N_CORES{w_res_en}};

    always_comb begin
        w_any_found = 1'b0;
        w_win_idx   = '0;
        w_found_cnt = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (w_found_gated[k]) begin
                w_any_found = 1'b1;
                w_win_idx   = PTR_W'(k);
            end
            w_found_cnt = w_found_cnt + 5'(w_found_gated[k]);
        end
        w_res_take = w_any_found & (~r_res_valid | i_res_ready);
        w_drop_n   = w_found_cnt - 5'(w_res_take);
        w_drop_sum = {1'b0, r_dropped} + 17'(w_drop_n);
    end

    assign w_win_nonce = i_core_nonce[32*w_win_idx +: 32];

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_core_work  <= '0;
            r_pend_work  <= '0;
            r_pend_valid <= 1'b0;
            r_core_start <= '0;
            r_holdoff    <= '0;
            r_core_base  <= '0;
            r_next_base  <= '0;
            r_chunks     <= '0;
            r_rr_ptr     <= '0;
            r_core_flush <= 1'b0;
            r_flush_done <= 1'b0;
            r_exhausted  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_nonce  <= '0;
            r_dropped    <= '0;
        end else begin
            r_core_start <= '0;
            r_holdoff    <= '0;
            r_core_flush <= 1'b0;
            if (r_core_flush) r_flush_done <= 1'b1;

            if ((r_state == S_IDLE) && w_work_accept) begin
                r_core_work <= i_work_data;
                r_next_base <= '0;
                r_chunks    <= '0;
                r_exhausted <= 1'b0;
            end

            if ((r_state == S_RUN) && w_work_accept) begin
                r_pend_work  <= i_work_data;
                r_pend_valid <= 1'b1;
                r_core_flush <= 1'b1;
                r_flush_done <= 1'b0;
            end

            if (w_flush_exit) begin
                r_core_work  <= r_pend_work;
                r_pend_valid <= 1'b0;
                r_flush_done <= 1'b0;
                r_next_base  <= '0;
                r_chunks     <= '0;
                r_exhausted  <= 1'b0;
                r_rr_ptr     <= '0;
            end

            if (w_start) begin
                r_core_start <= CORE_ONE << w_pick_idx;
                r_holdoff    <= CORE_ONE << w_pick_idx;
                r_core_base  <= w_base_now;
                // Wraps to 0 on the final chunk, together with the exhaustion flag.
                r_next_base  <= w_base_now + CHUNK_STEP;
                r_chunks     <= w_chunks_inc;
                r_exhausted  <= (w_chunks_inc == CHUNK_LIMIT);
                r_rr_ptr     <= (w_pick_idx == PTR_LAST) ? '0 : w_pick_idx + 1'b1;
            end

            if ((r_state == S_RUN) && w_work_accept) begin
                r_res_valid <= 1'b0;
            end else if (w_res_take) begin
                r_res_valid <= 1'b1;
                r_res_nonce <= w_win_nonce;
            end else if (r_res_valid && i_res_ready) begin
                r_res_valid <= 1'b0;
            end

            if (w_drop_n != '0) begin
                r_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_vault_work_scheduler.sv
// tb/tb_vault_work_scheduler.sv - scoreboard bench for vault_work_scheduler
module tb_vault_work_scheduler;

    localparam logic [639:0] W1 = {20{32'hA5A50001}};
    localparam logic [639:0] W2 = {20{32'h5A5A0002}};
    localparam logic [639:0] W3 = {20{32'h3C3C0003}};
    localparam logic [639:0] W4 = {20{32'h96960004}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         work_valid = 1'b0;
    logic [639:0] work_data = '0;
    logic [3:0]   busy = '0;
    logic [3:0]   clr = '0;
    logic [3:0]   found = '0;
    logic [127:0] nonce = '0;
    logic         res_ready = 1'b0;
    logic         work_ready;
    logic [639:0] core_work;
    logic [3:0]   core_start;
    logic [31:0]  core_base;
    logic         core_flush;
    logic         res_valid;
    logic [31:0]  res_nonce;
    logic         exhausted;
    logic [15:0]  dropped;

    logic         wv30 = 1'b0;
    logic [3:0]   busy30 = '0;
    logic [3:0]   clr30 = '0;
    logic [3:0]   found30 = '0;
    logic [127:0] nonce30 = '0;
    logic         rr30 = 1'b0;
    logic         wr30;
    logic [639:0] work30;
    logic [3:0]   start30;
    logic [31:0]  base30;
    logic         flush30;
    logic         rv30;
    logic [31:0]  rn30;
    logic         ex30;
    logic [15:0]  dc30;

    int n_pass = 0;
    int n_total = 0;
    int flush_cnt = 0;
    int flush30_cnt = 0;
    logic [35:0] sq[$];
    logic [35:0] sq30[$];
    logic [31:0] rq[$];

    always #5 clk = ~clk;

    vault_work_scheduler #(.N_CORES(4), .CHUNK_LOG2(20), .WORK_W(640)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_work_valid(work_valid), .o_work_ready(work_ready),
        .i_work_data(work_data), .o_core_work(core_work), .o_core_start(core_start),
        .o_core_base(core_base), .o_core_flush(core_flush), .i_core_busy(busy),
        .i_core_found(found), .i_core_nonce(nonce), .o_res_valid(res_valid),
        .i_res_ready(res_ready), .o_res_nonce(res_nonce), .o_exhausted(exhausted),
        .o_dropped_count(dropped)
    );

    vault_work_scheduler #(.N_CORES(4), .CHUNK_LOG2(30), .WORK_W(640)) u_dut30 (
        .i_clk(clk), .i_rst(rst), .i_work_valid(wv30), .o_work_ready(wr30),
        .i_work_data(W4), .o_core_work(work30), .o_core_start(start30),
        .o_core_base(base30), .o_core_flush(flush30), .i_core_busy(busy30),
        .i_core_found(found30), .i_core_nonce(nonce30), .o_res_valid(rv30),
        .i_res_ready(rr30), .o_res_nonce(rn30), .o_exhausted(ex30),
        .o_dropped_count(dc30)
    );

    // Core models: busy rises the cycle after start, drops when the driver clears it.
    always @(posedge clk) busy   <= (busy | core_start) & ~clr;
    always @(posedge clk) busy30 <= (busy30 | start30) & ~clr30;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitors: pop the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst && core_start != '0) begin
            if (sq.size() == 0) chk("unexpected_start", {92'd0, core_start, core_base}, 128'd0);
            else chk("start_base", {92'd0, core_start, core_base}, {92'd0, sq.pop_front()});
        end
        if (!rst && start30 != '0) begin
            if (sq30.size() == 0) chk("unexpected_start30", {92'd0, start30, base30}, 128'd0);
            else chk("start_base30", {92'd0, start30, base30}, {92'd0, sq30.pop_front()});
        end
        if (!rst && res_valid && res_ready) begin
            if (rq.size() == 0) chk("unexpected_result", {127'd0, res_valid}, 128'd0);
            else chk("res_nonce_taken", {96'd0, res_nonce}, {96'd0, rq.pop_front()});
        end
        if (core_flush) flush_cnt++;
        if (flush30) flush30_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push4(input bit which, input logic [31:0] inc);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] m;
            m = 4'b0001 << i;
            if (which) sq30.push_back({m, inc * 32'(i)});
            else sq.push_back({m, inc * 32'(i)});
        end
    endtask

    task automatic drain(input bit which);
        for (int i = 0; i < 40; i++) begin
            if ((which ? sq30.size() : sq.size()) == 0) break;
            step();
        end
        if (which) chk("start_q30_drained", 128'(sq30.size()), 128'd0);
        else chk("start_q_drained", 128'(sq.size()), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        sample();
        chk("reset_outputs", {41'd0, core_start, core_base, core_flush, res_valid, res_nonce, exhausted, dropped},
            128'd0);
        chk("reset_core_work", {127'd0, core_work == '0}, 128'd1);
        chk("ready_in_reset", {127'd0, work_ready}, 128'd0);
        step();
        rst = 1'b0;
        sample();
        chk("ready_after_reset", {127'd0, work_ready}, 128'd1);

        // Four starts in round-robin order, no fifth while all busy.
        step();
        push4(1'b0, 32'h00100000);
        work_valid = 1'b1;
        work_data  = W1;
        step();
        work_valid = 1'b0;
        drain(1'b0);
        repeat (3) step();
        chk("core_work_w1", {127'd0, core_work == W1}, 128'd1);

        // Core 2 frees up: rr_ptr 0 -> core 2, then rr_ptr 3 prefers core 3 over 2.
        sq.push_back({4'b0100, 32'h00400000});
        clr = 4'b0100;
        step();
        clr = '0;
        drain(1'b0);
        repeat (2) step();
        sq.push_back({4'b1000, 32'h00500000});
        sq.push_back({4'b0100, 32'h00600000});
        clr = 4'b1100;
        step();
        clr = '0;
        drain(1'b0);
        repeat (2) step();

        // Simultaneous finds: core 1 wins, core 3 dropped; blocked report dropped too.
        found = 4'b1010;
        nonce = {32'h12345678, 32'h0, 32'hDEADBEEF, 32'h0};
        step();
        found = '0;
        sample();
        chk("res_valid_set", {127'd0, res_valid}, 128'd1);
        chk("res_nonce_lowest", {96'd0, res_nonce}, {96'd0, 32'hDEADBEEF});
        chk("dropped_1", {112'd0, dropped}, 128'd1);
        step();
        found = 4'b0001;
        nonce = {96'd0, 32'hAAAA0000};
        step();
        found = '0;
        sample();
        chk("res_nonce_held", {96'd0, res_nonce}, {96'd0, 32'hDEADBEEF});
        chk("dropped_2", {112'd0, dropped}, 128'd2);
        rq.push_back(32'hDEADBEEF);
        step();
        res_ready = 1'b1;
        sample();
        step();
        res_ready = 1'b0;
        sample();
        chk("res_valid_cleared", {127'd0, res_valid}, 128'd0);

        // New work during RUN with a pending result.
        step();
        found = 4'b0001;
        nonce = {96'd0, 32'hCAFEF00D};
        step();
        found = '0;
        sample();
        chk("res_valid_before_flush", {127'd0, res_valid}, 128'd1);
        step();
        work_valid = 1'b1;
        work_data  = W2;
        step();
        work_valid = 1'b0;
        sample();
        chk("flush_pulse", {126'd0, core_flush, res_valid}, {126'd0, 2'b10});
        chk("ready_low_flush", {127'd0, work_ready}, 128'd0);
        step();
        sample();
        chk("flush_one_cycle", {126'd0, core_flush, work_ready}, 128'd0);
        push4(1'b0, 32'h00100000);
        clr = 4'b1111;
        step();
        clr = '0;
        drain(1'b0);
        chk("core_work_w2", {127'd0, core_work == W2}, 128'd1);
        chk("ready_after_flush", {127'd0, work_ready}, 128'd1);
        repeat (2) step();

        // Reset mid-RUN with a result pending.
        found = 4'b0100;
        nonce = {32'h0, 32'h0BADCAFE, 64'd0};
        step();
        found = '0;
        sample();
        chk("res_valid_before_rst", {127'd0, res_valid}, 128'd1);
        rst = 1'b1;
        step();
        sample();
        chk("midrun_reset_outputs",
            {41'd0, core_start, core_base, core_flush, res_valid, res_nonce, exhausted, dropped}, 128'd0);
        rst = 1'b0;
        clr = 4'b1111;
        step();
        clr = '0;
        push4(1'b0, 32'h00100000);
        work_valid = 1'b1;
        work_data  = W3;
        step();
        work_valid = 1'b0;
        drain(1'b0);
        chk("core_work_w3", {127'd0, core_work == W3}, 128'd1);

        // CHUNK_LOG2=30: four chunks exhaust the space, then back to IDLE.
        step();
        push4(1'b1, 32'h40000000);
        wv30 = 1'b1;
        step();
        wv30 = 1'b0;
        drain(1'b1);
        sample();
        chk("exhausted30", {127'd0, ex30}, 128'd1);
        clr30 = 4'b0001;
        step();
        clr30 = '0;
        repeat (4) step();
        chk("exhausted30_held", {127'd0, ex30}, 128'd1);
        clr30 = 4'b1111;
        step();
        clr30 = '0;
        repeat (2) step();
        chk("ready30_idle", {127'd0, wr30}, 128'd1);
        push4(1'b1, 32'h40000000);
        wv30 = 1'b1;
        step();
        wv30 = 1'b0;
        sample();
        chk("exhausted30_cleared", {127'd0, ex30}, 128'd0);
        drain(1'b1);
        repeat (2) step();

        chk("flush_count", 128'(flush_cnt), 128'd1);
        chk("flush30_count", 128'(flush30_cnt), 128'd0);
        chk("res_q_drained", 128'(rq.size()), 128'd0);
        chk("dropped_after_reset", {112'd0, dropped}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vault_work_scheduler.md
Name: vault_work_scheduler

Overview:
Sequences a bank of N_CORES parallel SHA-256d hash cores inside the vault mining layer. It accepts Stratum work packages, splits the 32-bit nonce space into fixed-size chunks, and dispatches the chunks round-robin to idle cores. It collects found-nonce reports into a single result register with a valid/ready handshake, and flushes all cores when new work preempts the current job.

Parameters:
N_CORES, 4, number of hash cores scheduled (1..16)
CHUNK_LOG2, 20, log2 of nonce chunk size per dispatch (8..31)
WORK_W, 640, work package (block header) width in bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
work_valid  in  1  new work offered
work_ready  out  1  scheduler accepts work this cycle
work_data  in  WORK_W  work package
core_work  out  WORK_W  latched current work, shared by all cores
core_start  out  N_CORES  one-hot, one-cycle start pulse
core_base  out  32  base nonce of the chunk, valid with core_start
core_flush  out  1  one-cycle abort pulse to all cores
core_busy  in  N_CORES  per-core busy, rises the cycle after start
core_found  in  N_CORES  per-core one-cycle found pulse
core_nonce  in  32*N_CORES  per-core found nonce; core i at bits [32i+31:32i]
res_valid  out  1  found nonce available
res_ready  in  1  consumer takes result
res_nonce  out  32  found nonce
exhausted  out  1  whole nonce space issued for current work
dropped_count  out  16  found reports lost, saturating

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0: core_work, core_start, core_base, core_flush, res_valid, res_nonce, exhausted, dropped_count.
  - Internal next_base=0, chunk counter=0, rr_ptr=0, holdoff mask=0, pending-work valid=0.
  - Reset mid-operation abandons all state; core_flush is not pulsed.
- work_ready: combinational, = ~rst & (state != FLUSH).
- States:
  - IDLE:
    - Accept on work_valid&work_ready: latch core_work, next_base=0, chunks=0, exhausted=0 -> RUN.
  - RUN, dispatch:
    - Eligible core = ~core_busy[i] & ~holdoff[i].
    - Each cycle, pick the first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_CORES.
    - Assert core_start[i] and core_base=next_base (both registered).
    - Set holdoff[i] for exactly the next cycle.
    - rr_ptr=i+1 mod N_CORES; next_base += 2^CHUNK_LOG2; chunks += 1.
    - Rate: at most one start per cycle.
  - RUN, exhaustion:
    - When chunks reaches 2^(32-CHUNK_LOG2), set exhausted=1; no further starts.
    - When exhausted and core_busy==0 and holdoff==0 -> IDLE.
  - RUN, new work:
    - Accept on work_valid: store it as pending, pulse core_flush next cycle, clear res_valid -> FLUSH.
    - A start is never issued in the accept cycle.
  - FLUSH:
    - work_ready=0; core_found is ignored.
    - When core_busy==0 (not earlier than the cycle after core_flush): load pending work to core_work, next_base=0, chunks=0, exhausted=0, rr_ptr=0 -> RUN.
- Latency:
  - Work accepted at cycle T -> first core_start at T+1 (from IDLE).
  - From FLUSH exit at cycle F -> first core_start at F+1.
- Results (RUN only; in IDLE, found pulses from draining cores are still captured):
  - If any core_found is set: the lowest index wins.
  - If res_valid=0 or (res_valid&res_ready) in the same cycle, load res_nonce and set res_valid next cycle.
  - Every other simultaneous or blocked report increments dropped_count, saturating at 0xFFFF.
  - res_valid&res_ready with no new report -> res_valid=0 next cycle.
  - res_nonce is held stable while res_valid=1 and res_ready=0.
- Arithmetic: next_base is 32-bit and wraps to 0 exactly when exhaustion is flagged. The chunk counter is 33-bit so CHUNK_LOG2 small values do not alias.

Test Plan:
- Reset, work_valid at T, all cores idle, defaults -> core_start 0001,0010,0100,1000 at T+1..T+4; core_base 0x00000000, 0x00100000, 0x00200000, 0x00300000; no start at T+5.
- Core 2 drops busy while 0..3 were started, rr_ptr=0 -> next start on core 2 with base 0x00400000; rr_ptr becomes 3.
- core_found=1010 same cycle, nonces core1=0xDEADBEEF, core3=0x12345678, res_ready=0 -> res_nonce=0xDEADBEEF; res_valid held; dropped_count=1; res_ready pulse clears res_valid next cycle.
- New work during RUN with res_valid=1 -> core_flush pulse one cycle later; res_valid=0; work_ready=0 until busy==0; then first start with base 0.
- CHUNK_LOG2=30, N_CORES=4 -> four starts, bases 0x0,0x40000000,0x80000000,0xC0000000; exhausted=1; after all busy fall -> IDLE with work_ready=1.
- rst asserted mid-RUN with res_valid=1 -> next cycle all outputs 0, no core_flush; fresh work restarts at base 0.
